// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage
// Write-back end of the MEM/WB pipeline register. It selects the write-back
// value, commits it to the integer register file (x0 is hardwired to zero),
// serves two decode read ports with optional same-cycle write-through bypass,
// and keeps the retired-instruction counter.
//
// Ports:
//   clk_I                       clock, all state changes on the rising edge
//   reset_I                     asynchronous active-low reset
//   enable_I                    WB advance qualifier, shared with MEM/WB
//   memReadData_I               extended load data
//   aluResult_I                 ALU result
//   reg_W_EN_I                  register write request
//   destRegWriteSel_I           write-back source select
//                               (00 alu, 01 mem, 10 pc+4, 11 imm)
//   currInstructionAddrPlus4_I  link value
//   imm_I                       immediate (LUI)
//   rdAddr_I                    destination register
//   opCode_I                    opcode, 7'h00 marks a bubble
//   rs1Addr_I / rs2Addr_I       read port addresses
//   rs1Data_O / rs2Data_O       read port data (combinational)
//   wbData_O                    selected write-back value, forwarded to EX
//   wbWriteActive_O             a commit happens at the next rising edge
//   instret_O                   retired-instruction count
module wb_regfile_stage #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter bit BYPASS_EN = 1'b1,
  parameter int CNT_W     = 64
) (
  input  logic             clk_I,
  input  logic             reset_I,
  input  logic             enable_I,
  input  logic [XLEN-1:0]  memReadData_I,
  input  logic [XLEN-1:0]  aluResult_I,
  input  logic             reg_W_EN_I,
  input  logic [1:0]       destRegWriteSel_I,
  input  logic [XLEN-1:0]  currInstructionAddrPlus4_I,
  input  logic [XLEN-1:0]  imm_I,
  input  logic [4:0]       rdAddr_I,
  input  logic [6:0]       opCode_I,
  input  logic [4:0]       rs1Addr_I,
  input  logic [4:0]       rs2Addr_I,
  output logic [XLEN-1:0]  rs1Data_O,
  output logic [XLEN-1:0]  rs2Data_O,
  output logic [XLEN-1:0]  wbData_O,
  output logic             wbWriteActive_O,
  output logic [CNT_W-1:0] instret_O
);

  logic [XLEN-1:0]  regs_q [NUM_REGS];
  logic [XLEN-1:0]  regs_d [NUM_REGS];
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;
  logic             write_active;
  logic             retire;

  // Write-back source mux.
  always_comb begin
    wbData_O = aluResult_I;
    case (destRegWriteSel_I)
      2'b00:   wbData_O = aluResult_I;
      2'b01:   wbData_O = memReadData_I;
      2'b10:   wbData_O = currInstructionAddrPlus4_I;
      2'b11:   wbData_O = imm_I;
      default: wbData_O = aluResult_I;
    endcase
  end

  // x0 writes never become active, so x0 storage stays zero; rd beyond the
  // implemented register count is also ignored.
  assign write_active    = reg_W_EN_I & enable_I & (rdAddr_I != 5'd0) &
                           (int'(rdAddr_I) < NUM_REGS);
  assign wbWriteActive_O = write_active;
  assign retire          = enable_I & (opCode_I != 7'h00);

  // Read port: zero for x0, bypass the in-flight write if enabled, else storage.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    if (addr == 5'd0 || int'(addr) >= NUM_REGS) begin
      val = '0;
    end else if (BYPASS_EN && write_active && (addr == rdAddr_I)) begin
      val = wbData_O;
    end else begin
      val = regs_q[addr];
    end
    return val;
  endfunction

  always_comb begin
    rs1Data_O = read_port(rs1Addr_I);
    rs2Data_O = read_port(rs2Addr_I);
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (write_active) begin
      regs_d[rdAddr_I] = wbData_O;
    end
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);   // wraps naturally
    end
  end

  always_ff @(posedge clk_I or negedge reset_I) begin
    if (!reset_I) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      instret_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      instret_q <= instret_d;
    end
  end

  assign instret_O = instret_q;

endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
- Write-back end of the MEM/WB pipeline register. It consumes the latched MEM/WB fields.
- Selects the write-back value and commits it to the architectural integer register file (x0 hardwired to zero).
- Serves the two decode-stage read ports, with same-cycle write-through bypass.
- Maintains the retired-instruction counter (instret).

Parameters:
- XLEN, 32, datapath and register width.
- NUM_REGS, 32, number of architectural registers; address width is 5 bits.
- BYPASS_EN, 1, 1 = a read of the register being written this cycle returns the new value; 0 = it returns the old stored value.
- CNT_W, 64, width of the instret counter.

Ports:
- clk_I  in  1  clock; all state updates on the rising edge.
- reset_I  in  1  reset, asynchronous and active-low.
- enable_I  in  1  WB advance qualifier; the same enable that drives the MEM/WB register.
- memReadData_I  in  XLEN  load data, already sign/zero-extended.
- aluResult_I  in  XLEN  ALU result.
- reg_W_EN_I  in  1  register write request.
- destRegWriteSel_I  in  2  write-back source select.
- currInstructionAddrPlus4_I  in  XLEN  PC+4, used as the link value.
- imm_I  in  XLEN  immediate (LUI).
- rdAddr_I  in  5  destination register.
- opCode_I  in  7  opcode; 7'h00 marks a bubble.
- rs1Addr_I  in  5  read port 1 address.
- rs2Addr_I  in  5  read port 2 address.
- rs1Data_O  out  XLEN  read port 1 data.
- rs2Data_O  out  XLEN  read port 2 data.
- wbData_O  out  XLEN  selected write-back value, for forwarding to EX.
- wbWriteActive_O  out  1  a commit occurs at the next edge.
- instret_O  out  CNT_W  retired-instruction count.

Behaviour:
- Write-back mux (combinational), driving wbData_O:
  - destRegWriteSel_I 2'b00 -> aluResult_I
  - 2'b01 -> memReadData_I
  - 2'b10 -> currInstructionAddrPlus4_I
  - 2'b11 -> imm_I
- wbWriteActive_O = reg_W_EN_I & enable_I & (rdAddr_I != 0). It is combinational.
- Commit:
  - On a rising edge with wbWriteActive_O = 1, regs[rdAddr_I] <= wbData_O.
  - Otherwise the storage is unchanged.
  - Writes to x0 are discarded; x0 always reads 0.
- Read ports:
  - Reads are combinational, with zero latency.
  - rsNData_O = 0 if rsNAddr_I == 0.
  - Else, if BYPASS_EN and wbWriteActive_O and rsNAddr_I == rdAddr_I, the output is wbData_O.
  - Else the output is regs[rsNAddr_I].
  - Both ports may read the same address at once, and both see identical data.
- Stall:
  - With enable_I = 0: no commit, no count, and the bypass is inactive.
  - The inputs may hold their values for any number of cycles. The instruction commits and counts exactly once, on the first edge where enable_I = 1.
- instret:
  - On a rising edge with enable_I = 1 and opCode_I != 7'h00: instret <= instret + 1.
  - The count wraps modulo 2^CNT_W without saturation.
  - Retirement is counted whether or not the instruction writes a register (stores and branches count). Bubbles never count.
- Reset (asserted asynchronously at any time, including mid-stall):
  - Immediately clears all NUM_REGS registers and instret to 0.
  - Read outputs then reflect the zero storage, subject only to the current combinational bypass.
  - wbData_O and wbWriteActive_O are combinational and follow their inputs.
  - Commit and count resume on the first rising edge after reset_I deasserts.
- Unknown or X values on destRegWriteSel_I when reg_W_EN_I = 0 must not affect storage.

Test Plan:
- Reset, then read x1..x31 on both ports -> all read 0; instret_O = 0.
- enable=1, reg_W_EN=1, rd=5, sel=00, alu=32'hDEADBEEF, rs1Addr=5 in the same cycle:
  - Same cycle -> rs1Data_O = 32'hDEADBEEF (bypass) and wbWriteActive_O = 1.
  - After the edge -> rs1Data_O = 32'hDEADBEEF, now from storage.
  - Repeat with BYPASS_EN=0 -> the same-cycle rs1Data_O returns the old value 0.
- Cycle through sel 01/10/11 with memRead=32'h11, PC+4=32'h104, imm=32'h12345000 into rd=1,2,3 -> x1=32'h11, x2=32'h104, x3=32'h12345000.
- rd=0, reg_W_EN=1, alu=32'hFFFFFFFF -> wbWriteActive_O = 0, x0 reads 0, and instret increments by 1.
- Stall: hold an instruction with enable=0 for 3 cycles, then enable=1 for 1 cycle. Insert a bubble (opCode=0) -> instret increments by exactly 1 in total; the register is written once.
- Preload instret to near wrap (CNT_W=8 build, 255 retirements) -> next retirement gives 0.
- Assert reset mid-stall -> storage and instret read 0 immediately, before the next clock edge.
